// File: rtl/ppi_bus_master.sv
// ppi_bus_master: single-transaction bus initiator for an 8255A PPI.
// A request handshake is turned into one nCs/nRe/nWr/A/D bus cycle with
// programmable setup/strobe/hold lengths, followed by a one-cycle
// completion pulse. All pins come straight from flops.
// Optional feature macro: PPI_MASTER_INIT_EN -- when defined, the block
// writes INIT_CW to the control register (A=3) right after reset, before
// accepting any request.
module ppi_bus_master #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 3,
    parameter int unsigned HOLD_CYC   = 1,
    parameter logic [7:0]  INIT_CW    = 8'h80
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [1:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       nCs,
    output logic       nRe,
    output logic       nWr,
    output logic [1:0] A,
    inout  wire  [7:0] D
);

    // Phase lengths must fit the 4-bit down-counter and be non-zero.
    if (SETUP_CYC < 32'd1 || SETUP_CYC > 32'd15) begin : g_bad_setup
        $error("ppi_bus_master: SETUP_CYC must be 1..15");
    end
    if (STROBE_CYC < 32'd1 || STROBE_CYC > 32'd15) begin : g_bad_strobe
        $error("ppi_bus_master: STROBE_CYC must be 1..15");
    end
    if (HOLD_CYC < 32'd1 || HOLD_CYC > 32'd15) begin : g_bad_hold
        $error("ppi_bus_master: HOLD_CYC must be 1..15");
    end

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 32'd1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 32'd1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 32'd1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

`ifdef PPI_MASTER_INIT_EN
    localparam state_t RST_STATE = ST_INIT;
    localparam logic   RST_READY = 1'b0;
    localparam logic   RST_INIT  = 1'b1;
`else
    localparam state_t RST_STATE = ST_IDLE;
    localparam logic   RST_READY = 1'b1;
    localparam logic   RST_INIT  = 1'b0;
`endif

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       write_q, write_d;
    logic [1:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] cap_q, cap_d;
    logic       init_q, init_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;
    logic       busy_q, busy_d;
    logic       req_ready_q, req_ready_d;
    logic       ncs_q, ncs_d;
    logic       nre_q, nre_d;
    logic       nwr_q, nwr_d;
    logic [1:0] a_q, a_d;
    logic       doe_q, doe_d;
    logic       bus_act;

    // Next-state, request latch, read capture and pin values for the next cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cap_d       = cap_q;
        init_d      = init_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    init_d  = 1'b0;
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INIT: begin
                // Latch registers reset to the start-up control-word write.
                state_d = ST_SETUP;
                cnt_d   = SETUP_LD;
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == 4'd0) begin
                    // Strobe rises on this edge: sample the PPI while it still drives.
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                    if (!write_q) begin
                        cap_d = D;
                    end else begin
                        cap_d = cap_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = !init_q;
                    if (!write_q && !init_q) begin
                        rsp_rdata_d = cap_q;
                    end else begin
                        rsp_rdata_d = rsp_rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        bus_act     = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
        ncs_d       = !bus_act;
        nre_d       = !((state_d == ST_STROBE) && !write_d);
        nwr_d       = !((state_d == ST_STROBE) && write_d);
        a_d         = bus_act ? addr_d : a_q;
        doe_d       = bus_act && write_d;
        busy_d      = (state_d != ST_IDLE);
        req_ready_d = (state_d == ST_IDLE);
    end

    // State, request latch and registered bus/response outputs.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= RST_STATE;
            cnt_q       <= 4'd0;
            write_q     <= 1'b1;
            addr_q      <= 2'd3;
            wdata_q     <= INIT_CW;
            cap_q       <= 8'h00;
            init_q      <= RST_INIT;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            busy_q      <= 1'b0;
            req_ready_q <= RST_READY;
            ncs_q       <= 1'b1;
            nre_q       <= 1'b1;
            nwr_q       <= 1'b1;
            a_q         <= 2'd0;
            doe_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cap_q       <= cap_d;
            init_q      <= init_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
            ncs_q       <= ncs_d;
            nre_q       <= nre_d;
            nwr_q       <= nwr_d;
            a_q         <= a_d;
            doe_q       <= doe_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;
    assign nCs       = ncs_q;
    assign nRe       = nre_q;
    assign nWr       = nwr_q;
    assign A         = a_q;
    assign D         = doe_q ? wdata_q : 8'hzz;

endmodule
